image_pack_loader: RTL

IMAGE_PACK_LOADER -- requirements
Module: image_pack_loader

---
 rtl/image_loader_pkg.sv | 27 ++
 rtl/image_pack_loader_if.sv | 12 +
 rtl/pixel_packer.sv | 54 +++++
 rtl/image_pack_loader.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/image_loader_pkg.sv
// Shared types and sizing helpers for the image pack loader.
package image_loader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int ROM_ADDR_W = 18;
   localparam int WR_ADDR_W  = 24;

   function automatic int ceil_div(input int num, input int den);
      return (num + den - 1) / den;
   endfunction

   function automatic int calc_ppw(input int data_width, input int pixel_bits);
      return data_width / pixel_bits;
   endfunction

   function automatic int calc_words(input int width, input int height,
                                     input int data_width, input int pixel_bits);
      return ceil_div(width * height, calc_ppw(data_width, pixel_bits));
   endfunction

endpackage

// File: rtl/image_pack_loader_if.sv
// SDRAM write port: packed word, word address and valid/ready handshake.
interface image_pack_loader_if #(
   parameter int DATA_WIDTH = 16
);
   logic [DATA_WIDTH-1:0] wr_data;
   logic [23:0]           wr_addr;
   logic                  wr_valid;
   logic                  wr_ready;

   modport master (output wr_data, output wr_addr, output wr_valid, input wr_ready);
   modport slave  (input wr_data, input wr_addr, input wr_valid, output wr_ready);
endinterface

// File: rtl/pixel_packer.sv
// Packs pixels LSB-first into a word; word_dat/word_vld are combinational with the
// pixel that completes it (PPW pixels or flush), no backpressure: caller gates pix_vld.
module pixel_packer
   import image_loader_pkg::*;
#(
   parameter int PIXEL_BITS = 3,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  pix_vld,
   input  logic [PIXEL_BITS-1:0] pix_dat,
   input  logic                  flush,
   output logic                  word_vld,
   output logic [DATA_WIDTH-1:0] word_dat
);

   localparam int PPW   = calc_ppw(DATA_WIDTH, PIXEL_BITS);
   localparam int CNT_W = $clog2(PPW + 1);

   logic [DATA_WIDTH-1:0] acc;
   logic [CNT_W-1:0]      cnt;

   always_comb begin
      word_dat = acc;
      for (int k = 0; k < PPW; k++) begin
         if (pix_vld && (cnt == CNT_W'(k)))
            word_dat[k*PIXEL_BITS +: PIXEL_BITS] = pix_dat;
      end
   end

   assign word_vld = pix_vld && ((cnt == CNT_W'(PPW - 1)) || flush);

   // Accumulator restarts from zero after every emitted word, so unused MSBs stay 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         cnt <= '0;
      end else if (clear) begin
         acc <= '0;
         cnt <= '0;
      end else if (pix_vld) begin
         if (word_vld) begin
            acc <= '0;
            cnt <= '0;
         end else begin
            acc <= word_dat;
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/image_pack_loader.sv
// Streams a ROM image into packed SDRAM words; ROM_LATENCY+1 cycles per pixel capture, holds
// each word until wr_ready. Optional checksum output enabled by IMAGE_LOADER_CHECKSUM_EN.
module image_pack_loader
   import image_loader_pkg::*;
#(
   parameter int IMG_WIDTH   = 320,
   parameter int IMG_HEIGHT  = 240,
   parameter int PIXEL_BITS  = 3,
   parameter int DATA_WIDTH  = 16,
   parameter int ROM_LATENCY = 1,
   parameter int BASE_ADDR   = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_loading,
   input  logic                  sdram_ready,
   input  logic                  abort,
   output logic [17:0]           rom_addr,
   input  logic [PIXEL_BITS-1:0] rom_pixel,
   image_pack_loader_if.master   wr,
   output logic                  busy,
   output logic                  loading_complete,
   output logic [17:0]           words_written
`ifdef IMAGE_LOADER_CHECKSUM_EN
   ,
   output logic [DATA_WIDTH-1:0] checksum
`endif
);

   localparam int          PPW       = calc_ppw(DATA_WIDTH, PIXEL_BITS);
   localparam int          WORDS     = calc_words(IMG_WIDTH, IMG_HEIGHT, DATA_WIDTH, PIXEL_BITS);
   localparam int          CNT_W     = $clog2(PPW + 1);
   localparam logic [17:0] LAST_IDX  = 18'(IMG_WIDTH * IMG_HEIGHT - 1);
   localparam logic [17:0] LAST_WORD = 18'(WORDS - 1);

   state_t                state;
   logic [17:0]           pix_idx;
   logic [17:0]           cap_idx;
   logic [CNT_W-1:0]      iss_cnt;
   logic                  iss_done;
   logic [ROM_LATENCY:0]  pipe;
   logic [DATA_WIDTH-1:0] wr_data_q;
   logic [23:0]           wr_addr_q;
   logic                  wr_valid_q;

   logic                  start_go;
   logic                  issue;
   logic                  cap_en;
   logic                  flush;
   logic                  xfer;
   logic                  pk_clear;
   logic                  pk_word_vld;
   logic [DATA_WIDTH-1:0] pk_word;

   assign wr.wr_data  = wr_data_q;
   assign wr.wr_addr  = wr_addr_q;
   assign wr.wr_valid = wr_valid_q;

   assign start_go = !abort && ((state == IDLE) || (state == DONE)) && start_loading && sdram_ready;
   // Issue at most PPW reads per word, so every in-flight read lands before WRITE.
   assign issue    = !abort && (state == FETCH) && !iss_done && (iss_cnt < CNT_W'(PPW));
   assign cap_en   = !abort && (state == FETCH) && pipe[ROM_LATENCY];
   assign flush    = (cap_idx == LAST_IDX);
   assign xfer     = (state == WRITE) && wr_valid_q && wr.wr_ready;
   assign pk_clear = abort || start_go;

   pixel_packer #(
      .PIXEL_BITS (PIXEL_BITS),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_packer (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (pk_clear),
      .pix_vld  (cap_en),
      .pix_dat  (rom_pixel),
      .flush    (flush),
      .word_vld (pk_word_vld),
      .word_dat (pk_word)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         pix_idx          <= '0;
         cap_idx          <= '0;
         iss_cnt          <= '0;
         iss_done         <= 1'b0;
         pipe             <= '0;
         rom_addr         <= '0;
         wr_data_q        <= '0;
         wr_addr_q        <= 24'(BASE_ADDR);
         wr_valid_q       <= 1'b0;
         busy             <= 1'b0;
         loading_complete <= 1'b0;
         words_written    <= '0;
`ifdef IMAGE_LOADER_CHECKSUM_EN
         checksum         <= '0;
`endif
      end else begin
         pipe <= (abort || start_go) ? '0 : {pipe[ROM_LATENCY-1:0], issue};

         if (abort) begin
            // A handshake completing in the abort cycle still counts as written.
            if (xfer) begin
               words_written <= words_written + 18'd1;
               wr_addr_q     <= wr_addr_q + 24'd1;
`ifdef IMAGE_LOADER_CHECKSUM_EN
               checksum      <= checksum ^ wr_data_q;
`endif
            end
            state            <= IDLE;
            wr_valid_q       <= 1'b0;
            busy             <= 1'b0;
            loading_complete <= 1'b0;
            iss_done         <= 1'b0;
            iss_cnt          <= '0;
         end else begin
            case (state)
               IDLE, DONE: begin
                  if (start_go) begin
                     state            <= FETCH;
                     pix_idx          <= '0;
                     cap_idx          <= '0;
                     iss_cnt          <= '0;
                     iss_done         <= 1'b0;
                     words_written    <= '0;
                     wr_addr_q        <= 24'(BASE_ADDR);
                     busy             <= 1'b1;
                     loading_complete <= 1'b0;
`ifdef IMAGE_LOADER_CHECKSUM_EN
                     checksum         <= '0;
`endif
                  end
               end

               FETCH: begin
                  if (issue) begin
                     rom_addr <= pix_idx;
                     pix_idx  <= pix_idx + 18'd1;
                     iss_cnt  <= iss_cnt + CNT_W'(1);
                     if (pix_idx == LAST_IDX)
                        iss_done <= 1'b1;
                  end
                  if (cap_en) begin
                     cap_idx <= cap_idx + 18'd1;
                     if (pk_word_vld) begin
                        state      <= WRITE;
                        wr_data_q  <= pk_word;
                        wr_valid_q <= 1'b1;
                     end
                  end
               end

               WRITE: begin
                  if (wr.wr_ready) begin
                     wr_valid_q    <= 1'b0;
                     words_written <= words_written + 18'd1;
                     wr_addr_q     <= wr_addr_q + 24'd1;
                     iss_cnt       <= '0;
`ifdef IMAGE_LOADER_CHECKSUM_EN
                     checksum      <= checksum ^ wr_data_q;
`endif
                     if (words_written == LAST_WORD) begin
                        state            <= DONE;
                        busy             <= 1'b0;
                        loading_complete <= 1'b1;
                     end else begin
                        state <= FETCH;
                     end
                  end
               end

               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
